// File: rtl/sync_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared constants and helpers for the sync_debounce block.
//   SYNC_STAGES_MIN     : shallowest synchroniser chain accepted by the top.
//   DEBOUNCE_CYCLES_MIN : smallest debounce window (1 = no filtering).
//   GLITCH_CNT_W        : width of each per-channel aborted-transition counter
//                         (only used when SYNC_DEBOUNCE_GLITCH_CNT_EN is defined).
//   cnt_width()         : width of the debounce counter for a given window.
// -----------------------------------------------------------------------------
package sync_pkg;

   localparam int SYNC_STAGES_MIN     = 2;
   localparam int DEBOUNCE_CYCLES_MIN = 1;
   localparam int GLITCH_CNT_W        = 8;

   // Counter must be able to hold DEBOUNCE_CYCLES-1.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// -----------------------------------------------------------------------------
// sync_debounce_ch
// One channel of sync_debounce: flop-chain synchroniser, debounce counter,
// debounced level and one-cycle edge strobes.
// Optional feature (macro SYNC_DEBOUNCE_GLITCH_CNT_EN): saturating count of
// transitions that were aborted before the debounce window completed.
// Ports:
//   clock        : sole clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_async      : asynchronous input bit
//   o_level      : debounced, synchronised level
//   o_rise       : one-cycle strobe when o_level goes 0->1
//   o_fall       : one-cycle strobe when o_level goes 1->0
//   o_glitch_cnt : aborted-transition count (macro builds only)
// -----------------------------------------------------------------------------
module sync_debounce_ch
   import sync_pkg::*;
#(
   parameter int   SYNC_STAGES     = 3,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clock,
   input  logic i_rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [GLITCH_CNT_W-1:0] o_glitch_cnt
`endif
);

   localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] chain_p;
   logic [CNT_W-1:0]       cnt;
   logic                   synced;

   assign synced = chain_p[SYNC_STAGES-1];

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction
`endif

   always_ff @(posedge clock) begin
      if (i_rst) begin
         chain_p <= {SYNC_STAGES{RESET_LEVEL}};
         o_level <= RESET_LEVEL;
         cnt     <= '0;
         o_rise  <= 1'b0;
         o_fall  <= 1'b0;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
         o_glitch_cnt <= '0;
`endif
      end else begin
         // Synchroniser boundary: pure shift, no logic between stages.
         chain_p <= {chain_p[SYNC_STAGES-2:0], i_async};
         o_rise  <= 1'b0;
         o_fall  <= 1'b0;
         // Debounce boundary: accept a new level only after it has held for
         // the whole window; any return to the current level restarts it.
         if (synced == o_level) begin
            cnt <= '0;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
            if (cnt != '0) o_glitch_cnt <= sat_inc(o_glitch_cnt);
`endif
         end else if (cnt == CNT_LAST) begin
            o_level <= synced;
            cnt     <= '0;
            o_rise  <= synced;
            o_fall  <= ~synced;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
// Multi-channel synchroniser + debounce filter with registered edge strobes,
// for pads and async status lines entering the `clock` domain.
// Optional feature (macro SYNC_DEBOUNCE_GLITCH_CNT_EN): adds o_glitch_cnt,
// 8 bits per channel, channel c at [8c+7:8c].
// Ports:
//   clock        : sole clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_async      : [CHANNELS] asynchronous inputs
//   o_level      : [CHANNELS] debounced synchronised levels
//   o_rise       : [CHANNELS] one-cycle 0->1 strobes
//   o_fall       : [CHANNELS] one-cycle 1->0 strobes
//   o_glitch_cnt : [CHANNELS*8] aborted-transition counters (macro builds only)
// -----------------------------------------------------------------------------
module sync_debounce
   import sync_pkg::*;
#(
   parameter int   CHANNELS        = 1,
   parameter int   SYNC_STAGES     = 3,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic                clock,
   input  logic                i_rst,
   input  logic [CHANNELS-1:0] i_async,
   output logic [CHANNELS-1:0] o_level,
   output logic [CHANNELS-1:0] o_rise,
   output logic [CHANNELS-1:0] o_fall
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [CHANNELS*GLITCH_CNT_W-1:0] o_glitch_cnt
`endif
);

   if (CHANNELS < 1) begin : g_bad_channels
      $error("sync_debounce: CHANNELS must be >= 1");
   end
   if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
      $error("sync_debounce: SYNC_STAGES below minimum");
   end
   if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_debounce
      $error("sync_debounce: DEBOUNCE_CYCLES below minimum");
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      sync_debounce_ch #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_LEVEL    (RESET_LEVEL)
      ) u_ch (
         .clock  (clock),
         .i_rst  (i_rst),
         .i_async(i_async[c]),
         .o_level(o_level[c]),
         .o_rise (o_rise[c]),
         .o_fall (o_fall[c])
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
         ,
         .o_glitch_cnt(o_glitch_cnt[c*GLITCH_CNT_W +: GLITCH_CNT_W])
`endif
      );
   end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Multi-channel successor to the single-bit synchroniser.
- Each channel passes through a parametrised-depth flop chain into the `clock` domain.
- Each channel then runs a per-channel debounce filter and produces registered rising- and falling-edge strobes.
- Sits at the chip boundary between pads (buttons, straps, async status lines) and synchronous control logic.

Parameters:
- CHANNELS, 1: number of independent async inputs; min 1.
- SYNC_STAGES, 3: synchroniser flop depth per channel; min 2.
- DEBOUNCE_CYCLES, 4: consecutive cycles a new synced value must hold before it is accepted; min 1 (1 = no filtering).
- RESET_LEVEL, 1'b0: value loaded into every chain flop and every o_level bit on reset.

Ports:
- clock  input  1  sole clock, rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_async  input  CHANNELS  asynchronous inputs, one bit per channel.
- o_level  output  CHANNELS  debounced, synchronised level.
- o_rise  output  CHANNELS  one-cycle strobe on the cycle o_level goes 0->1.
- o_fall  output  CHANNELS  one-cycle strobe on the cycle o_level goes 1->0.

Behaviour:
- Single clock `clock`. Reset `i_rst` is synchronous and active-high.
- Reset, sampled on a `clock` edge:
  - all chain flops and o_level = RESET_LEVEL;
  - debounce counters = 0;
  - o_rise = o_fall = 0.
- Reset dominates every other update in the same cycle.
- Chain: stage0 <= i_async[c]; stage k <= stage k-1. The synced value s[c] is stage SYNC_STAGES-1. No logic between stages.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1), unsigned, one per channel.
  - If s == o_level: counter <= 0.
  - If s != o_level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If s != o_level and counter == DEBOUNCE_CYCLES-1: o_level <= s and counter <= 0. In the same edge, o_rise or o_fall <= 1 according to direction.
- o_rise/o_fall are cleared on every other edge, so each is exactly one cycle wide. Both are never high together on a channel.
- Latency: o_level changes on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge, counting the edge that first samples the new i_async value. Defaults: 7 edges.
- Glitch rejection: a synced pulse shorter than DEBOUNCE_CYCLES cycles resets the counter and produces no output change.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes.
- Reset mid-count: the count is discarded and no strobe is emitted.
- After reset with an input held opposite to RESET_LEVEL, the block emits a normal edge strobe once latency elapses. This is intended behaviour.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.

Optional Feature:
- Macro: SYNC_DEBOUNCE_GLITCH_CNT_EN.
- Defined: adds output o_glitch_cnt, width CHANNELS*8, channel c at bits [8c+7:8c].
  - Increments (saturating at 255) when s returns to o_level while that channel's counter is non-zero, i.e. a transition was aborted.
  - Reset to 0 by i_rst.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package sync_pkg holds:
  - SYNC_STAGES_MIN = 2, DEBOUNCE_CYCLES_MIN = 1, GLITCH_CNT_W = 8;
  - a counter-width function.
- Top checks parameters against the minimums with an elaboration-time error.
- Sub-module sync_debounce_ch: one channel (chain, counter, level, strobes, optional glitch counter). The top instantiates it CHANNELS times in a generate loop and concatenates outputs.

Test Plan:
- Reset value, defaults: i_rst high 2 cycles with i_async=1 -> o_level=0, o_rise=0 during reset. After release, o_rise=1 for exactly one cycle on edge 7 after release; o_level=1 thereafter.
- Step and latency: CHANNELS=1, i_async 0->1 just before edge N -> o_level=1 and o_rise=1 first visible after edge N+6. o_rise low after edge N+7. Repeat 1->0 for o_fall.
- Glitch rejection: DEBOUNCE_CYCLES=4, synced high pulse of 3 cycles -> o_level stays 0, no strobes. With SYNC_DEBOUNCE_GLITCH_CNT_EN, o_glitch_cnt=1.
- Multi-channel: CHANNELS=4, i_async=4'b1010 applied at once -> o_rise=4'b1010 in a single cycle, o_fall=0. Then 4'b0110 -> o_rise=4'b0100 and o_fall=4'b1000 in the same cycle.
- Reset mid-operation: new level held for SYNC_STAGES+2 cycles, then i_rst pulsed 1 cycle -> no strobe; counter restarts, full latency measured from reset release.
- Pass-through mode: DEBOUNCE_CYCLES=1, SYNC_STAGES=2 -> every 1-cycle synced pulse reproduced on o_level, with latency 3 edges.
- Glitch-counter saturation: with SYNC_DEBOUNCE_GLITCH_CNT_EN, 300 aborted pulses -> o_glitch_cnt=255.
